mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, placed directly downstream of the EX/MEM pipeline register. It owns the byte-addressed data memory and performs word, halfword and byte loads and stores. It selects the write-back address and write-back data, and registers the result into the MEM/WB pipeline register consumed by the register file.

## Interface
- `DEPTH_WORDS`, default 256: data-memory depth in 32-bit words; power of two, ≥ 4.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `PCNext_in` input 32: PC+4 of the instruction; the link value for jal/jalr.
- `ReadData2_in` input 32: store data (rt).
- `state_of_type_in` input 2: access size. 00 word, 01 halfword signed, 10 byte signed, 11 byte unsigned.
- `data_mem_en_in` input 1: store enable.
- `ALU_result_in` input 32: effective byte address for memory ops; otherwise the ALU result.
- `wb_data_sel_in` input 1: 1 selects load data for write-back, 0 selects the ALU result.
- `PC_sel_in` input 1: 1 selects `PCNext_in` as write-back data (link); has priority over `wb_data_sel_in`.
- `wb_addr_sel_in` input 1: 1 selects `wb_addr2_in` (rd), 0 selects `wb_addr1_in` (rt).
- `wb_write_en_in` input 1: register-file write request.
- `wb_addr1_in`, `wb_addr2_in` input 5: candidate destination registers.
- `wb_data_out` output 32: registered write-back data.
- `wb_addr_out` output 5: registered destination register.
- `wb_write_en_out` output 1: registered write enable.
- `fwd_data` output 32: combinational write-back data of the current MEM instruction, for the forwarding unit.
- `fwd_addr` output 5: combinational destination register of the current MEM instruction.
- `fwd_en` output 1: combinational; equals the qualified write enable.

## Operation
- Word index: `ALU_result_in[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS bytes.
- Byte offset `off = ALU_result_in[1:0]`. Little-endian: byte k lives in bits [8k+7:8k].
- Alignment is not checked.
  - Word: `off` is ignored.
  - Halfword: `off[0]` is ignored; `off[1]` selects the half.
  - Byte: all of `off` is used.
- Stores (`data_mem_en_in`=1) use per-byte write enables.
  - Word: writes all 4 bytes with `ReadData2_in`.
  - Halfword: writes 2 bytes with `ReadData2_in[15:0]`.
  - Byte (10 or 11): writes 1 byte with `ReadData2_in[7:0]`.
  - Unselected bytes are unchanged.
- Loads:
  - The addressed word is read combinationally from the array.
  - The selected lane is extracted and extended: 01 and 10 sign-extend, 11 zero-extends, 00 passes the full word.
- Write-back data: `PC_sel_in ? PCNext_in : wb_data_sel_in ? load_data : ALU_result_in`.
- Write-back address: `wb_addr_sel_in ? wb_addr2_in : wb_addr1_in`.
- Qualified write enable: `wb_write_en_in && (wb_addr != 0)`. Writes to r0 are squashed here.
- `fwd_*` outputs carry the qualified combinational values of the instruction currently in MEM.

## Timing
- Store: array is updated on the rising edge of the cycle in which `data_mem_en_in`=1.
- Load and pass-through: data reaches `wb_data_out` one edge after the instruction is presented. Latency is 1 cycle, the same as every other MEM/WB field.
- Store followed by a load to the same word in the next cycle: the load returns the newly written data (write-first across cycles).
- A single instruction never loads and stores in the same cycle. If both are asserted, the load observes pre-store contents.
- Reset asserted:
  - `wb_data_out`=0, `wb_addr_out`=0, `wb_write_en_out`=0, immediately and asynchronously.
  - Stores are blocked while reset is low.
  - Memory contents are not cleared.
- Reset released mid-stream: the first edge with reset high captures the current inputs normally.
- No stall or flush inputs. Bubbles arrive from upstream as `wb_write_en_in`=0 and `data_mem_en_in`=0.

## Structure
- Shared package `mips_pkg` holds:
  - The `state_of_type` encodings: `ST_WORD`=2'b00, `ST_HALF`=2'b01, `ST_BYTE`=2'b10, `ST_BYTEU`=2'b11.
  - The 32-bit data width constant.
- Sub-module `data_mem` contains:
  - The `DEPTH_WORDS`×32 array with 4-bit byte-write enables.
  - A synchronous write port and an asynchronous read port.
- Lane extraction, extension, muxing and the MEM/WB register stay in `mem_stage`.

## Test plan
- Reset low with random inputs: all three registered outputs hold 0 and the memory is unchanged; release reset, then a pass-through with `ALU_result_in`=0x1234, `wb_addr2_in`=5, `wb_addr_sel_in`=1, `wb_write_en_in`=1 gives `wb_data_out`=0x1234, `wb_addr_out`=5, `wb_write_en_out`=1 after one edge.
- Store word 0xDEADBEEF at address 0x10, then load word at 0x10 in the next cycle: `wb_data_out`=0xDEADBEEF. Byte loads: at 0x13 signed gives 0xFFFFFFDE; at 0x10 unsigned gives 0x000000EF.
- Store halfword 0x8001 at 0x22 over an existing 0x11111111: the word reads 0x80011111. Halfword signed load at 0x22 gives 0xFFFF8001.
- Store byte 0xAB at 0x05: only bits [15:8] of word 1 change. An address of `4*DEPTH_WORDS+5` hits the same byte (wrap).
- Link: `PC_sel_in`=1 with `wb_data_sel_in`=1, `PCNext_in`=0x400 gives `wb_data_out`=0x400. Setting `wb_write_en_in`=1 with a selected address of 0 gives `wb_write_en_out`=0 and `fwd_en`=0.
- Reset pulsed low mid-stream between a store and a load: outputs clear, the stored word survives, and a load after reset returns the stored value.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings, data width and
// the byte-enable helper used by the memory stage.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_WORD  = 2'b00,
        ST_HALF  = 2'b01,
        ST_BYTE  = 2'b10,
        ST_BYTEU = 2'b11
    } state_of_type_e;

    // Little-endian byte lanes touched by an access of size st at offset off.
    function automatic logic [3:0] byte_enables(input logic [1:0] st, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (st)
            ST_WORD:          be = 4'b1111;
            ST_HALF:          be = off[1] ? 4'b1100 : 4'b0011;
            ST_BYTE, ST_BYTEU: be = 4'b0001 << off;
            default:          be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-writable data memory: synchronous write port, asynchronous read port.
// Contents are not cleared by reset; writes are only blocked while it is low.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    // Per-byte write of the addressed word; reset only holds the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access, load extension, write-back selection
// and the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PCNext_in,
    input  logic [31:0]       ReadData2_in,
    input  logic [1:0]        state_of_type_in,
    input  logic              data_mem_en_in,
    input  logic [31:0]       ALU_result_in,
    input  logic              wb_data_sel_in,
    input  logic              PC_sel_in,
    input  logic              wb_addr_sel_in,
    input  logic              wb_write_en_in,
    input  logic [4:0]        wb_addr1_in,
    input  logic [4:0]        wb_addr2_in,
    output logic [31:0]       wb_data_out,
    output logic [4:0]        wb_addr_out,
    output logic              wb_write_en_out,
    output logic [31:0]       fwd_data,
    output logic [4:0]        fwd_addr,
    output logic              fwd_en
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0]     word_idx_s;
    logic [1:0]        off_s;
    logic [3:0]        be_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
    logic [15:0]       half_s;
    logic [7:0]        byte_s;
    logic [DATA_W-1:0] load_data_s;

    logic [31:0] wb_data_d, wb_data_q;
    logic [4:0]  wb_addr_d, wb_addr_q;
    logic        wb_write_en_d, wb_write_en_q;

    assign word_idx_s = ALU_result_in[AW+1:2];
    assign off_s      = ALU_result_in[1:0];

    // Store lanes: data is replicated so the byte enables alone pick the lane.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = ReadData2_in;
        if (data_mem_en_in) begin
            be_s = byte_enables(state_of_type_in, off_s);
        end else begin
            be_s = 4'b0000;
        end
        case (state_of_type_in)
            ST_WORD: wdata_s = ReadData2_in;
            ST_HALF: wdata_s = {2{ReadData2_in[15:0]}};
            default: wdata_s = {4{ReadData2_in[7:0]}};
        endcase
    end

    data_mem #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_data_mem (
        .clk   (clk),
        .reset (reset),
        .we    (be_s),
        .addr  (word_idx_s),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Load lane extraction and sign/zero extension.
    always_comb begin
        half_s      = off_s[1] ? rdata_s[31:16] : rdata_s[15:0];
        byte_s      = 8'h00;
        load_data_s = rdata_s;
        case (off_s)
            2'd0:    byte_s = rdata_s[7:0];
            2'd1:    byte_s = rdata_s[15:8];
            2'd2:    byte_s = rdata_s[23:16];
            2'd3:    byte_s = rdata_s[31:24];
            default: byte_s = 8'h00;
        endcase
        case (state_of_type_in)
            ST_WORD:  load_data_s = rdata_s;
            ST_HALF:  load_data_s = {{16{half_s[15]}}, half_s};
            ST_BYTE:  load_data_s = {{24{byte_s[7]}}, byte_s};
            ST_BYTEU: load_data_s = {24'h000000, byte_s};
            default:  load_data_s = rdata_s;
        endcase
    end

    // Write-back selection; link has priority, writes to r0 are squashed.
    always_comb begin
        wb_data_d     = ALU_result_in;
        wb_addr_d     = wb_addr1_in;
        wb_write_en_d = 1'b0;
        if (PC_sel_in) begin
            wb_data_d = PCNext_in;
        end else if (wb_data_sel_in) begin
            wb_data_d = load_data_s;
        end else begin
            wb_data_d = ALU_result_in;
        end
        if (wb_addr_sel_in) begin
            wb_addr_d = wb_addr2_in;
        end else begin
            wb_addr_d = wb_addr1_in;
        end
        wb_write_en_d = wb_write_en_in && (wb_addr_d != 5'd0);
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data_q     <= 32'h0000_0000;
            wb_addr_q     <= 5'd0;
            wb_write_en_q <= 1'b0;
        end else begin
            wb_data_q     <= wb_data_d;
            wb_addr_q     <= wb_addr_d;
            wb_write_en_q <= wb_write_en_d;
        end
    end

    assign wb_data_out     = wb_data_q;
    assign wb_addr_out     = wb_addr_q;
    assign wb_write_en_out = wb_write_en_q;
    assign fwd_data        = wb_data_d;
    assign fwd_addr        = wb_addr_d;
    assign fwd_en          = wb_write_en_d;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each driven cycle queues its expected
// MEM/WB contents, and a monitor compares them after the following edge.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] PCNext_in;
    logic [31:0] ReadData2_in;
    logic [1:0]  state_of_type_in;
    logic        data_mem_en_in;
    logic [31:0] ALU_result_in;
    logic        wb_data_sel_in;
    logic        PC_sel_in;
    logic        wb_addr_sel_in;
    logic        wb_write_en_in;
    logic [4:0]  wb_addr1_in;
    logic [4:0]  wb_addr2_in;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_addr_out;
    logic        wb_write_en_out;
    logic [31:0] fwd_data;
    logic [4:0]  fwd_addr;
    logic        fwd_en;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [4:0]  a;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_stage #(.DEPTH_WORDS(256)) dut (
        .clk              (clk),
        .reset            (reset),
        .PCNext_in        (PCNext_in),
        .ReadData2_in     (ReadData2_in),
        .state_of_type_in (state_of_type_in),
        .data_mem_en_in   (data_mem_en_in),
        .ALU_result_in    (ALU_result_in),
        .wb_data_sel_in   (wb_data_sel_in),
        .PC_sel_in        (PC_sel_in),
        .wb_addr_sel_in   (wb_addr_sel_in),
        .wb_write_en_in   (wb_write_en_in),
        .wb_addr1_in      (wb_addr1_in),
        .wb_addr2_in      (wb_addr2_in),
        .wb_data_out      (wb_data_out),
        .wb_addr_out      (wb_addr_out),
        .wb_write_en_out  (wb_write_en_out),
        .fwd_data         (fwd_data),
        .fwd_addr         (fwd_addr),
        .fwd_en           (fwd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endfunction

    // One pipeline slot: drive at negedge, queue what MEM/WB must hold next.
    task automatic cyc(input string nm, input logic rst, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [31:0] pcn, input logic [1:0] ty,
                       input logic men, input logic wsel, input logic psel, input logic asel,
                       input logic wen, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] ed, input logic [4:0] ea, input logic ewe);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        ALU_result_in    = alu;
        ReadData2_in     = rd2;
        PCNext_in        = pcn;
        state_of_type_in = ty;
        data_mem_en_in   = men;
        wb_data_sel_in   = wsel;
        PC_sel_in        = psel;
        wb_addr_sel_in   = asel;
        wb_write_en_in   = wen;
        wb_addr1_in      = a1;
        wb_addr2_in      = a2;
        e.name = nm;
        e.d    = rst ? ed  : 32'h0;
        e.a    = rst ? ea  : 5'd0;
        e.we   = rst ? ewe : 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".data"}, wb_data_out, e.d);
                chk({e.name, ".addr"}, {27'd0, wb_addr_out}, {27'd0, e.a});
                chk({e.name, ".we"},   {31'd0, wb_write_en_out}, {31'd0, e.we});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        PCNext_in = 32'h0; ReadData2_in = 32'h0; state_of_type_in = 2'b00;
        data_mem_en_in = 1'b0; ALU_result_in = 32'h0; wb_data_sel_in = 1'b0;
        PC_sel_in = 1'b0; wb_addr_sel_in = 1'b0; wb_write_en_in = 1'b0;
        wb_addr1_in = 5'd0; wb_addr2_in = 5'd0;

        for (int i = 0; i < 3; i++) begin
            cyc("rst_rand", 1'b0, $urandom, $urandom, $urandom, 2'($urandom_range(3)),
                1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b1,
                5'($urandom_range(31)), 5'($urandom_range(31)), 32'h0, 5'd0, 1'b0);
        end
        //   name       rst   alu            rd2            pcn            ty     men   wsel  psel  asel  wen   a1     a2     exp_d          ea     ewe
        cyc("pass",     1'b1, 32'h0000_1234, 32'h0,         32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  5'd5,  32'h0000_1234, 5'd5,  1'b1);
        cyc("st_w10",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0010, 5'd0,  1'b0);
        cyc("ld_w10",   1'b1, 32'h0000_0010, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  5'd0,  32'hDEAD_BEEF, 5'd8,  1'b1);
        cyc("ld_b13",   1'b1, 32'h0000_0013, 32'h0,         32'h0,         2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  5'd0,  32'hFFFF_FFDE, 5'd9,  1'b1);
        cyc("ld_bu10",  1'b1, 32'h0000_0010, 32'h0,         32'h0,         2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  5'd10, 32'h0000_00EF, 5'd10, 1'b1);
        cyc("st_w20",   1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0,         2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0020, 5'd0,  1'b0);
        cyc("st_h22",   1'b1, 32'h0000_0022, 32'h1234_8001, 32'h0,         2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0022, 5'd0,  1'b0);
        cyc("ld_w20",   1'b1, 32'h0000_0020, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 5'd0,  32'h8001_1111, 5'd11, 1'b1);
        cyc("ld_h22",   1'b1, 32'h0000_0022, 32'h0,         32'h0,         2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 5'd0,  32'hFFFF_8001, 5'd12, 1'b1);
        cyc("ld_h23",   1'b1, 32'h0000_0023, 32'h0,         32'h0,         2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 5'd0,  32'hFFFF_8001, 5'd12, 1'b1);
        cyc("ld_h20",   1'b1, 32'h0000_0020, 32'h0,         32'h0,         2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 5'd0,  32'h0000_1111, 5'd13, 1'b1);
        cyc("st_w04",   1'b1, 32'h0000_0004, 32'h0000_0000, 32'h0,         2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0004, 5'd0,  1'b0);
        cyc("st_b05",   1'b1, 32'h0000_0005, 32'hFFFF_FFAB, 32'h0,         2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0005, 5'd0,  1'b0);
        cyc("ld_w04",   1'b1, 32'h0000_0004, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 5'd0,  32'h0000_AB00, 5'd14, 1'b1);
        cyc("ld_wrap",  1'b1, 32'h0000_0405, 32'h0,         32'h0,         2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 5'd0,  32'h0000_00AB, 5'd15, 1'b1);
        cyc("st_bwrap", 1'b1, 32'h0000_0407, 32'h0000_00CD, 32'h0,         2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0407, 5'd0,  1'b0);
        cyc("ld_w04b",  1'b1, 32'h0000_0004, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd16, 5'd0,  32'hCD00_AB00, 5'd16, 1'b1);
        cyc("link",     1'b1, 32'h0000_0010, 32'h0,         32'h0000_0400, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  5'd31, 32'h0000_0400, 5'd31, 1'b1);
        #1;
        chk("fwd_link.data", fwd_data, 32'h0000_0400);
        chk("fwd_link.en",   {31'd0, fwd_en}, 32'd1);
        cyc("r0_squash",1'b1, 32'h0000_0099, 32'h0,         32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd9,  32'h0000_0099, 5'd0,  1'b0);
        #1;
        chk("fwd_r0.en",   {31'd0, fwd_en}, 32'd0);
        chk("fwd_r0.addr", {27'd0, fwd_addr}, 32'd0);
        cyc("bubble",   1'b1, 32'h0000_0000, 32'h0,         32'h0,         2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  32'h0000_0000, 5'd0,  1'b0);
        cyc("st_w30",   1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'h0,         2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  5'd0,  32'h0000_0030, 5'd3,  1'b1);
        cyc("rst_mid0", 1'b0, 32'h0000_0030, 32'h5555_5555, 32'h0,         2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  5'd0,  32'h0,          5'd0,  1'b0);
        #1;
        chk("rst_async.data", wb_data_out, 32'h0);
        chk("rst_async.addr", {27'd0, wb_addr_out}, 32'd0);
        chk("rst_async.we",   {31'd0, wb_write_en_out}, 32'd0);
        cyc("rst_mid1", 1'b0, 32'h0000_0031, 32'h7777_7777, 32'h0,         2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  5'd0,  32'h0,          5'd0,  1'b0);
        cyc("ld_w30",   1'b1, 32'h0000_0030, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  5'd0,  32'hCAFE_F00D, 5'd4,  1'b1);
        cyc("ld_w10b",  1'b1, 32'h0000_0010, 32'h0,         32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6,  5'd0,  32'hDEAD_BEEF, 5'd6,  1'b1);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
